// File: rtl/m_seq_pkg.sv
// rtl/m_seq_pkg.sv - shared constants and LFSR helpers for the M-sequence transmitter
package m_seq_pkg;

    localparam int unsigned MAX_ORDER = 15;
    localparam int unsigned MIN_DIV   = 2;

    // Maximal-length tap masks; bit n-1 set for tap n.
    function automatic logic [MAX_ORDER-1:0] tap_mask(input int unsigned order);
        case (order)
            3:       tap_mask = 15'h0006;
            4:       tap_mask = 15'h000C;
            5:       tap_mask = 15'h0014;
            6:       tap_mask = 15'h0030;
            7:       tap_mask = 15'h0060;
            8:       tap_mask = 15'h00B8;
            9:       tap_mask = 15'h0110;
            10:      tap_mask = 15'h0240;
            11:      tap_mask = 15'h0500;
            12:      tap_mask = 15'h0829;
            13:      tap_mask = 15'h100D;
            14:      tap_mask = 15'h2015;
            15:      tap_mask = 15'h6000;
            default: tap_mask = '0;
        endcase
    endfunction

    function automatic logic [MAX_ORDER-1:0] lfsr_shift(input logic [MAX_ORDER-1:0] s,
                                                        input int unsigned order);
        logic [MAX_ORDER-1:0] keep;
        logic                 fb;
        keep = MAX_ORDER'((32'd1 << order) - 32'd1);
        fb   = ^(s & tap_mask(order));
        return {s[MAX_ORDER-2:0], fb} & keep;
    endfunction

endpackage

// File: rtl/m_seq_lfsr.sv
// rtl/m_seq_lfsr.sv - Fibonacci LFSR with seed load and all-zero lockup recovery
module m_seq_lfsr
    import m_seq_pkg::*;
#(
    parameter int unsigned      ORDER = 7,
    parameter logic [ORDER-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [ORDER-1:0] state
);

    logic [ORDER-1:0] state_q;
    logic [ORDER-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = (state_q == '0) ? SEED
                                      : ORDER'(lfsr_shift(MAX_ORDER'(state_q), ORDER));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/m_seq_tx.sv
// rtl/m_seq_tx.sv - M-sequence serial transmitter with bit clock, bit strobe and frame sync
module m_seq_tx
    import m_seq_pkg::*;
#(
    parameter int unsigned      ORDER = 7,
    parameter int unsigned      DIV_W = 32,
    parameter logic [ORDER-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_cfg,
    output logic             m_out,
    output logic             bit_clk,
    output logic             bit_stb,
    output logic             frame_sync
);

    localparam logic [ORDER-1:0] IDX_LAST = ORDER'((32'd1 << ORDER) - 32'd2);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);

    logic             en_q, en_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [ORDER-1:0] idx_q, idx_d;
    logic             m_out_q, m_out_d;
    logic             bit_clk_q, bit_clk_d;
    logic             bit_stb_q, bit_stb_d;
    logic             frame_sync_q, frame_sync_d;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [ORDER-1:0] lfsr_state;
    logic [ORDER-1:0] nxt_state;
    logic [DIV_W-1:0] div_eff;

    m_seq_lfsr #(
        .ORDER (ORDER),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    always_comb begin
        en_d         = en;
        cnt_d        = cnt_q;
        div_d        = div_q;
        idx_d        = idx_q;
        m_out_d      = m_out_q;
        bit_clk_d    = bit_clk_q;
        bit_stb_d    = 1'b0;
        frame_sync_d = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        div_eff      = (div_cfg < DIV_MIN) ? DIV_MIN : div_cfg;
        // m_out is registered alongside the LFSR, so predict the MSB it will hold after the step.
        nxt_state    = (lfsr_state == '0) ? SEED
                                          : ORDER'(lfsr_shift(MAX_ORDER'(lfsr_state), ORDER));

        if (!en) begin
            cnt_d     = '0;
            idx_d     = '0;
            m_out_d   = 1'b0;
            bit_clk_d = 1'b0;
            lfsr_load = 1'b1;
        end else if (!en_q) begin
            cnt_d        = '0;
            idx_d        = '0;
            div_d        = div_eff;
            lfsr_load    = 1'b1;
            m_out_d      = SEED[ORDER-1];
            bit_clk_d    = 1'b1;
            bit_stb_d    = 1'b1;
            frame_sync_d = 1'b1;
        end else if (cnt_q == div_q - 1'b1) begin
            cnt_d        = '0;
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            div_d        = div_eff;
            lfsr_step    = 1'b1;
            m_out_d      = nxt_state[ORDER-1];
            bit_clk_d    = 1'b1;
            bit_stb_d    = 1'b1;
            frame_sync_d = (idx_q == IDX_LAST);
        end else begin
            cnt_d     = cnt_q + 1'b1;
            bit_clk_d = (cnt_d < (div_q >> 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            cnt_q        <= '0;
            div_q        <= DIV_MIN;
            idx_q        <= '0;
            m_out_q      <= 1'b0;
            bit_clk_q    <= 1'b0;
            bit_stb_q    <= 1'b0;
            frame_sync_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            m_out_q      <= m_out_d;
            bit_clk_q    <= bit_clk_d;
            bit_stb_q    <= bit_stb_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    assign m_out      = m_out_q;
    assign bit_clk    = bit_clk_q;
    assign bit_stb    = bit_stb_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_m_seq_tx.sv
// tb/tb_m_seq_tx.sv - directed self-checking bench for m_seq_tx (ORDER=7)
module tb_m_seq_tx;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] div_cfg;
    logic        m_out;
    logic        bit_clk;
    logic        bit_stb;
    logic        frame_sync;

    int   n_cmp;
    int   n_bad;
    logic exp_bits [0:126];

    m_seq_tx #(
        .ORDER (7),
        .DIV_W (32),
        .SEED  (7'h7F)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_cfg    (div_cfg),
        .m_out      (m_out),
        .bit_clk    (bit_clk),
        .bit_stb    (bit_stb),
        .frame_sync (frame_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_seq(input logic [31:0] dv);
        en      = 1'b0;
        div_cfg = dv;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    // Caller must be at the negedge of the first cycle of bit 0.
    task automatic check_run(input string tag, input int div, input int ncyc,
                             output int ones, output int first7);
        int e_stb, e_clk, e_fs, e_m, ph, eb;
        e_stb = 0; e_clk = 0; e_fs = 0; e_m = 0;
        ones = 0; first7 = 0;
        for (int k = 0; k < ncyc; k++) begin
            ph = k % div;
            eb = (k / div) % 127;
            if (bit_stb !== (ph == 0)) e_stb++;
            if (bit_clk !== (ph < div / 2)) e_clk++;
            if (frame_sync !== ((k % (div * 127)) == 0)) e_fs++;
            if (m_out !== exp_bits[eb]) e_m++;
            if (ph == 0 && k < div * 127) begin
                ones += int'(m_out);
                if (k / div < 7) first7 = (first7 << 1) | int'(m_out);
            end
            @(negedge clk);
        end
        chk_eq({tag, "_stb"}, e_stb, 0);
        chk_eq({tag, "_bitclk"}, e_clk, 0);
        chk_eq({tag, "_fsync"}, e_fs, 0);
        chk_eq({tag, "_mout"}, e_m, 0);
    endtask

    initial begin
        int ones, f7, e_stb, e_clk, e_m, e_z;
        logic xs, xc;
        int   xb;
        n_cmp = 0;
        n_bad = 0;

        // b[k+7] = b[k] ^ b[k+1] for x^7 taps 7,6 shifting toward the MSB
        for (int i = 0; i < 7; i++) exp_bits[i] = 1'b1;
        for (int i = 0; i < 120; i++) exp_bits[i + 7] = exp_bits[i] ^ exp_bits[i + 1];

        rst_n = 1'b0; en = 1'b0; div_cfg = 32'd4;
        @(negedge clk);
        chk_eq("reset_outputs", {28'd0, m_out, bit_clk, bit_stb, frame_sync}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("idle_outputs", {28'd0, m_out, bit_clk, bit_stb, frame_sync}, 32'd0);

        // div 4: two full periods plus the third frame start
        start_seq(32'd4);
        check_run("div4", 4, 1020, ones, f7);
        chk_eq("ones_per_period", ones, 64);
        chk_eq("first7_bits", f7, 32'h7F);

        start_seq(32'd5);
        check_run("div5", 5, 60, ones, f7);

        start_seq(32'd0);
        check_run("div0", 2, 40, ones, f7);

        start_seq(32'd1);
        check_run("div1", 2, 40, ones, f7);

        // div_cfg 4 -> 10 during bit 0: bit 0 lasts 4, bit 1 lasts 10
        start_seq(32'd4);
        e_stb = 0; e_clk = 0; e_m = 0;
        for (int k = 0; k < 16; k++) begin
            xs = (k == 0 || k == 4 || k == 14);
            xc = (k < 2) || (k >= 4 && k < 9) || (k >= 14);
            xb = (k < 4) ? 0 : ((k < 14) ? 1 : 2);
            if (bit_stb !== xs) e_stb++;
            if (bit_clk !== xc) e_clk++;
            if (m_out !== exp_bits[xb]) e_m++;
            if (k == 1) div_cfg = 32'd10;
            @(negedge clk);
        end
        chk_eq("divchg_stb", e_stb, 0);
        chk_eq("divchg_bitclk", e_clk, 0);
        chk_eq("divchg_mout", e_m, 0);

        // en dropped in the last cycle of bit 50, coinciding with its boundary
        start_seq(32'd4);
        check_run("pre_drop", 4, 203, ones, f7);
        en = 1'b0;
        @(negedge clk);
        e_z = 0;
        for (int k = 0; k < 20; k++) begin
            if ({m_out, bit_clk, bit_stb, frame_sync} !== 4'b0000) e_z++;
            @(negedge clk);
        end
        chk_eq("en_low_outputs", e_z, 0);
        en = 1'b1;
        @(negedge clk);
        check_run("restart", 4, 40, ones, f7);

        // asynchronous reset mid-bit while bit_clk is high
        start_seq(32'd4);
        check_run("pre_rst", 4, 37, ones, f7);
        rst_n = 1'b0;
        #1;
        chk_eq("async_rst_outputs", {28'd0, m_out, bit_clk, bit_stb, frame_sync}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_run("post_rst", 4, 40, ones, f7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
